// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants, FSM state type and baud divisor helper for UART
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int STOP_ONE = 1;
    localparam int STOP_TWO = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with occupancy count and full/empty flags
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full     = (r_count == C_DEPTH);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_push_ok  = i_push & ~o_full;
    assign w_pop_ok   = i_pop & ~o_empty;

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Parametrised UART transmitter fed by a valid/ready FIFO
// Revision : 1.0
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] C_DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             C_LAST_STOP = 1'(STOP_BITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_fifo: baud divisor must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_data_bits_check
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (STOP_BITS != STOP_ONE && STOP_BITS != STOP_TWO) begin : g_stop_bits_check
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_parity_check
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end

    tx_state_t             r_state;
    logic [CNT_W-1:0]      r_baud_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_stop_idx;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_busy;

    logic                  w_tick;
    logic                  w_last_stop;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_pop_parity;
    logic [DATA_BITS-1:0]  w_pop_data;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (in_valid),
        .i_push_data (in_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_count     (fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign in_ready     = ~w_fifo_full;
    assign tx           = r_tx;
    assign busy         = r_busy;
    assign w_tick       = (r_baud_cnt == C_DIV_LAST);
    assign w_last_stop  = (r_stop_idx == C_LAST_STOP);
    assign w_pop_parity = (PARITY == PAR_ODD) ? ~^w_pop_data : ^w_pop_data;
    assign w_pop        = ~w_fifo_empty &
                          ((r_state == ST_IDLE) ||
                           (r_state == ST_STOP && w_tick && w_last_stop));

    // Idle holds the counter at zero, so every START begins a full bit period.
    always_ff @(posedge clk) begin
        if (!reset_n || r_state == ST_IDLE || w_tick) r_baud_cnt <= '0;
        else                                          r_baud_cnt <= r_baud_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_pop_data;
                        r_parity <= w_pop_parity;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == C_LAST_IDX) begin
                            r_stop_idx <= 1'b0;
                            if (PARITY != PAR_NONE) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (!w_last_stop) begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end else if (w_pop) begin
                            // Back-to-back frame: straight into the next start bit.
                            r_shift  <= w_pop_data;
                            r_parity <= w_pop_parity;
                            r_tx     <= 1'b0;
                            r_state  <= ST_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 button-driven transmitter.
- Runs entirely on the 100 MHz system clock. The baud rate comes from an internal clock-enable tick, not a derived clock.
- Configurable data width, parity and stop bits.
- A small synchronous FIFO with valid/ready handshake sits in front of the framer, so upstream logic (button/edge-detect front ends, test pattern generators) can queue bytes without gaps.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DATA_BITS, 8, payload bits per frame; legal 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- FIFO_DEPTH, 4, entries; power of two, >= 2.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- reset_n, in, 1, synchronous active-low reset.
- in_data, in, DATA_BITS, byte to transmit.
- in_valid, in, 1, in_data valid.
- in_ready, out, 1, FIFO can accept; equals (fifo_count != FIFO_DEPTH).
- tx, out, 1, serial line, idle high, registered.
- busy, out, 1, high while a frame is on the line, registered.
- fifo_count, out, $clog2(FIFO_DEPTH)+1, entries currently queued.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset_n). All flops clear on a rising clk edge with reset_n=0.
- Reset values: tx=1, busy=0, fifo_count=0, in_ready=1, FSM=IDLE, baud counter=0.
- Divisor: DIV = (CLK_HZ + BAUD/2) / BAUD, integer rounding to nearest. Elaboration error if DIV < 2.
- Baud counter: counts 0..DIV-1 only when FSM != IDLE.
  - bit_tick asserts when counter == DIV-1; counter wraps to 0.
  - Counter is forced to 0 on entry to START, so every bit lasts exactly DIV cycles.
- Push: accepted on an edge where in_valid & in_ready. When full, in_ready=0 even if a pop occurs that same cycle.
- fifo_count update per cycle: +1 on push only, -1 on pop only, unchanged when both or neither.
- FSM states:
  - IDLE: if fifo_count != 0, pop head into shift register, tx<=0, busy<=1, go START.
  - START: on bit_tick, tx<=shift[0], bit index<=0, go DATA.
  - DATA: on bit_tick, shift right. If index == DATA_BITS-1: go PARITY (PARITY != 0) or STOP; otherwise index+1 and tx<=next bit. Transmission is LSB first.
  - PARITY: tx = XOR of payload for even, inverted XOR for odd. On bit_tick go STOP.
  - STOP: tx=1 for STOP_BITS x DIV cycles. At the final tick, if the FIFO is non-empty, pop and go directly to START with tx<=0 (no idle gap). Otherwise go IDLE, busy<=0.
- Frame length: DIV x (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
- Latency: a push into an empty FIFO while IDLE at edge N gives pop at edge N+1. tx is low from edge N+1.
- Payload is captured at pop. Later FIFO activity never alters the frame in flight.
- Reset mid-frame: at the next edge tx returns to 1 and the FIFO is flushed. No partial-frame continuation after release.
- in_data bits above DATA_BITS do not exist; no truncation logic.

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - stop-bit constants;
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP);
  - function baud_div(clk_hz, baud) implementing the rounding rule.
- One sub-module, sync_fifo (params WIDTH, DEPTH): single clock, reset_n, push/pop, count, full/empty. It also serves future RX work.
- Baud counter and framer FSM stay in uart_tx_fifo.

Test Plan:
- All cases use CLK_HZ=1000000, BAUD=100000, so DIV=10, unless stated otherwise.
- 8N1, push 0xA5 once.
  -> tx low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles.
  -> busy high exactly 100 cycles; tx falls 1 cycle after acceptance.
- PARITY=2, push 0x07.
  -> parity bit 1; frame 110 cycles.
- PARITY=1, push 0x07.
  -> parity bit 0.
- DATA_BITS=7, STOP_BITS=2, push 0x55.
  -> 7 data bits 1,0,1,0,1,0,1, then 20 stop cycles; frame 100 cycles.
- FIFO_DEPTH=4, hold in_valid with data 0x01..0x06.
  -> in_ready drops while fifo_count==4.
  -> six frames leave back-to-back with no idle cycle between stop and next start.
  -> order 0x01..0x06 preserved; busy stays high for 600 cycles.
- Pull reset_n low for 1 cycle during DATA bit 3 with 2 entries queued.
  -> next edge: tx=1, busy=0, fifo_count=0.
  -> a subsequent push of 0x3C produces one clean frame.
- Default params (CLK_HZ=100000000, BAUD=115200).
  -> DIV=868; start bit measures 868 cycles.
